up_rst_seq: RTL and testbench
=============================

// Module: up_rst_seq
// PURPOSE
//  Parametrised reset sequencer and watchdog for up_core based systems. Holds N
//  downstream active-low resets (ch_nRst) asserted, then releases them in staggered
//  order. Once all are released it runs a kickable watchdog. Watchdog expiry or a
//  software request re-runs the sequence. Replaces fixed bench-side reset/timeout timing.
// PARAMETERS
//  CHANNELS      4   number of ch_nRst outputs, >=1; ch 0 released first
//  HOLD_CYCLES   5   cycles all channels stay asserted in ASSERT, >=1
//  STAGGER       2   cycles between successive channel releases, >=1
//  TIMEOUT_W     16  width of watchdog limit/counter
//  AUTO_RESTART  1   1: expiry re-enters ASSERT; 0: expiry parks in HALT
// PORTS
//  clk          in   1          system clock, all state on rising edge
//  rst          in   1          asynchronous, active-high reset
//  sw_rst_req   in   1          1-cycle pulse: restart sequence (cause=SW)
//  wdt_en       in   1          watchdog counts only while high
//  wdt_kick     in   1          clears watchdog counter
//  wdt_limit    in   TIMEOUT_W  expiry threshold in cycles; 0 = watchdog off
//  ch_nRst      out  CHANNELS   per-channel active-low reset to downstream blocks
//  ready        out  1          all channels released, state RUN
//  halted       out  1          state HALT
//  cause        out  2          last restart cause: 00 POR, 01 SW, 10 WDT
//  restart_cnt  out  8          restarts since rst, saturates at 255
// BEHAVIOUR
//  Reset, asynchronous: ch_nRst=0 (all asserted), ready=0, halted=0, cause=00,
//   restart_cnt=0, state=ASSERT, cnt=0, wdt counter=0.
//  States: ASSERT -> RELEASE -> RUN -> (ASSERT | HALT).
//  ASSERT: all ch_nRst=0. cnt increments each cycle.
//   At cnt==HOLD_CYCLES-1: ch_nRst[0]<=1, cnt<=0, go to RELEASE (or RUN if CHANNELS==1).
//   After ASSERT entry, ch 0 rises on the HOLD_CYCLES-th edge.
//  RELEASE: channel k+1 rises STAGGER edges after channel k. Released channels stay
//   high. ready<=1 on the same edge the last channel rises; state becomes RUN.
//  RUN: wdt counter cleared on entry. Each cycle, evaluated in this order:
//   wdt_kick -> counter 0; else wdt_en && wdt_limit!=0 -> counter+1.
//   Expiry: counter==wdt_limit-1 && wdt_en && !wdt_kick && wdt_limit!=0.
//   AUTO_RESTART=1: ASSERT, cause=10. AUTO_RESTART=0: HALT, cause=10.
//   wdt_en low freezes the counter; it does not clear it.
//  HALT: ch_nRst=0, halted=1, ready=0. Left only by rst or sw_rst_req.
//  sw_rst_req in any state: next edge all ch_nRst=0, ready=0, halted=0, cnt=0,
//   state=ASSERT, cause=01. Mid-sequence, the sequence restarts from zero.
//  Priority on one edge: sw_rst_req > kick > expiry. sw_rst_req plus expiry gives cause=01.
//  Re-entering ASSERT, whether by SW or WDT, increments restart_cnt. No increment at 255.
//  rst asserted mid-sequence: immediate asynchronous return to reset values. cause=00.
//  All outputs are registered; no combinational path from inputs to outputs.
// TESTING
//  1 Defaults, rst high->low at edge E: ch_nRst 0000->0001@E+5, 0011@E+7, 0111@E+9,
//    1111@E+11; ready=1@E+11; cause=00; restart_cnt=0.
//  2 RUN, wdt_en=1, wdt_limit=10, no kick: ready drops 10 cycles after RUN entry,
//    ch_nRst=0000, cause=10, restart_cnt=1; ready returns 11 cycles later.
//  3 wdt_limit=10, kick every 9 cycles for 200 cycles: no expiry. Then kick coincident
//    with the expiry cycle: no expiry. wdt_limit=0: no expiry ever.
//  4 sw_rst_req pulse when ch_nRst=0011: next edge 0000, cause=01, restart_cnt+1,
//    full 11-cycle release repeats. Repeat with sw_rst_req on the expiry cycle: cause=01.
//  5 AUTO_RESTART=0, expiry: halted=1, ch_nRst=0 held for 100 cycles.
//    sw_rst_req -> halted=0, sequence runs.
//  6 CHANNELS=1, HOLD_CYCLES=1: ch_nRst and ready rise 1 edge after rst release.
//    Force 300 expiries: restart_cnt sticks at 255. rst mid-RELEASE: all outputs reset at once.

Source files
------------

// File: rtl/up_rst_seq.sv
// Reset sequencer and watchdog for up_core based systems.
// Holds CHANNELS active-low resets asserted, releases them one by one (channel 0 first),
// then supervises the running system with a kickable watchdog. Watchdog expiry or a
// software request restarts the whole sequence; with AUTO_RESTART=0 expiry parks in HALT.
module up_rst_seq #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned HOLD_CYCLES  = 5,
  parameter int unsigned STAGGER      = 2,
  parameter int unsigned TIMEOUT_W    = 16,
  parameter bit          AUTO_RESTART = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sw_rst_req,
  input  logic                 wdt_en,
  input  logic                 wdt_kick,
  input  logic [TIMEOUT_W-1:0] wdt_limit,
  output logic [CHANNELS-1:0]  ch_nRst,
  output logic                 ready,
  output logic                 halted,
  output logic [1:0]           cause,
  output logic [7:0]           restart_cnt
);

  // Phase counter only ever has to reach max(HOLD_CYCLES, STAGGER) - 1.
  localparam int unsigned CntMax = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned IdxW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [CntW-1:0]      HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0]      StagLast = CntW'(STAGGER - 1);
  localparam logic [IdxW-1:0]      IdxLast  = IdxW'(CHANNELS - 1);
  localparam logic [TIMEOUT_W-1:0] WdtOne   = TIMEOUT_W'(1);

  localparam logic [1:0] CausePor = 2'b00;
  localparam logic [1:0] CauseSw  = 2'b01;
  localparam logic [1:0] CauseWdt = 2'b10;

  typedef enum logic [1:0] {
    StAssert,
    StRelease,
    StRun,
    StHalt
  } state_e;

  state_e                 state;
  logic [CntW-1:0]        cnt;
  logic [IdxW-1:0]        idx;       // next channel to release while in StRelease
  logic [TIMEOUT_W-1:0]   wdt_cnt;

  logic                   wdt_active;
  logic                   wdt_expire;
  logic [7:0]             restart_cnt_inc;

  // Watchdog decode and saturating restart counter increment.
  always_comb begin
    wdt_active      = wdt_en && (wdt_limit != '0);
    // A kick in the same cycle always wins over expiry.
    wdt_expire      = wdt_active && !wdt_kick && (wdt_cnt == (wdt_limit - WdtOne));
    restart_cnt_inc = (restart_cnt == 8'hFF) ? restart_cnt : (restart_cnt + 8'd1);
  end

  // Sequencer FSM; every output is a flop written here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StAssert;
      cnt         <= '0;
      idx         <= '0;
      wdt_cnt     <= '0;
      ch_nRst     <= '0;
      ready       <= 1'b0;
      halted      <= 1'b0;
      cause       <= CausePor;
      restart_cnt <= 8'd0;
    end else if (sw_rst_req) begin
      // Software restart beats every other event, including a coincident expiry.
      state       <= StAssert;
      cnt         <= '0;
      idx         <= '0;
      ch_nRst     <= '0;
      ready       <= 1'b0;
      halted      <= 1'b0;
      cause       <= CauseSw;
      restart_cnt <= restart_cnt_inc;
    end else begin
      unique case (state)
        StAssert: begin
          if (cnt == HoldLast) begin
            ch_nRst[0] <= 1'b1;
            cnt        <= '0;
            if (CHANNELS == 1) begin
              state   <= StRun;
              ready   <= 1'b1;
              wdt_cnt <= '0;
            end else begin
              state <= StRelease;
              idx   <= IdxW'(1);
            end
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end

        StRelease: begin
          if (cnt == StagLast) begin
            ch_nRst[idx] <= 1'b1;
            cnt          <= '0;
            if (idx == IdxLast) begin
              state   <= StRun;
              ready   <= 1'b1;
              wdt_cnt <= '0;
            end else begin
              idx <= idx + IdxW'(1);
            end
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end

        StRun: begin
          if (wdt_kick) begin
            wdt_cnt <= '0;
          end else if (wdt_expire) begin
            ch_nRst <= '0;
            ready   <= 1'b0;
            cause   <= CauseWdt;
            cnt     <= '0;
            idx     <= '0;
            if (AUTO_RESTART) begin
              state       <= StAssert;
              restart_cnt <= restart_cnt_inc;
            end else begin
              state  <= StHalt;
              halted <= 1'b1;
            end
          end else if (wdt_active) begin
            wdt_cnt <= wdt_cnt + WdtOne;
          end
        end

        StHalt: begin
          // Parked with all channels asserted until rst or sw_rst_req.
          ch_nRst <= '0;
          ready   <= 1'b0;
          halted  <= 1'b1;
        end

        default: begin
          state   <= StAssert;
          cnt     <= '0;
          idx     <= '0;
          ch_nRst <= '0;
          ready   <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // Output consistency: ready only with every channel released, halted only with none.
  a_ready_all_released: assert property (@(posedge clk) disable iff (rst)
    ready |-> (&ch_nRst));
  a_halt_all_asserted: assert property (@(posedge clk) disable iff (rst)
    halted |-> (ch_nRst == '0));
  a_ready_halt_excl: assert property (@(posedge clk) disable iff (rst)
    !(ready && halted));
`endif

endmodule

// File: tb/tb_up_rst_seq.sv
// Bench for up_rst_seq: three instances (defaults, AUTO_RESTART=0, single channel with
// HOLD_CYCLES=1) share one set of inputs and are compared against an elapsed-time model.
module tb_up_rst_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        sw_rst_req;
  logic        wdt_en;
  logic        wdt_kick;
  logic [15:0] wdt_limit;

  logic [3:0] ch0, ch1;
  logic [0:0] ch2;
  logic       ready0, ready1, ready2;
  logic       halted0, halted1, halted2;
  logic [1:0] cause0, cause1, cause2;
  logic [7:0] rcnt0, rcnt1, rcnt2;

  int tests = 0;
  int failures = 0;

  // Model: per instance, edges since the sequence (re)started, halt flag, watchdog count.
  int         m_t[3];
  bit         m_halt[3];
  int         m_wdt[3];
  logic [1:0] m_cause[3];
  logic [7:0] m_rcnt[3];

  always #5 clk = ~clk;

  up_rst_seq u_dut0 (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .wdt_en(wdt_en), .wdt_kick(wdt_kick),
    .wdt_limit(wdt_limit), .ch_nRst(ch0), .ready(ready0), .halted(halted0),
    .cause(cause0), .restart_cnt(rcnt0)
  );

  up_rst_seq #(.AUTO_RESTART(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .wdt_en(wdt_en), .wdt_kick(wdt_kick),
    .wdt_limit(wdt_limit), .ch_nRst(ch1), .ready(ready1), .halted(halted1),
    .cause(cause1), .restart_cnt(rcnt1)
  );

  up_rst_seq #(.CHANNELS(1), .HOLD_CYCLES(1)) u_dut2 (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .wdt_en(wdt_en), .wdt_kick(wdt_kick),
    .wdt_limit(wdt_limit), .ch_nRst(ch2), .ready(ready2), .halted(halted2),
    .cause(cause2), .restart_cnt(rcnt2)
  );

  function automatic int p_c(input int k);  return (k == 2) ? 1 : 4;  endfunction
  function automatic int p_h(input int k);  return (k == 2) ? 1 : 5;  endfunction
  function automatic int p_s(input int k);  return 2;                 endfunction
  function automatic bit p_ar(input int k); return (k == 1) ? 1'b0 : 1'b1; endfunction
  function automatic int rel_time(input int k);
    return p_h(k) + (p_c(k) - 1) * p_s(k);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'd255) ? v : v + 8'd1;
  endfunction

  // Bundle layout: {ch[3:0], ready, halted, cause[1:0], restart_cnt[7:0]}
  function automatic logic [15:0] obs_bus(input int k);
    case (k)
      0:       return {ch0, ready0, halted0, cause0, rcnt0};
      1:       return {ch1, ready1, halted1, cause1, rcnt1};
      default: return {3'b000, ch2, ready2, halted2, cause2, rcnt2};
    endcase
  endfunction

  function automatic logic [15:0] exp_bus(input int k);
    logic [3:0] ch;
    logic       rdy;
    ch = '0;
    for (int i = 0; i < p_c(k); i++) ch[i] = !m_halt[k] && (m_t[k] >= p_h(k) + i * p_s(k));
    rdy = !m_halt[k] && (m_t[k] >= rel_time(k));
    return {ch, rdy, m_halt[k], m_cause[k], m_rcnt[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_t[k] = 0; m_halt[k] = 1'b0; m_wdt[k] = 0; m_cause[k] = 2'b00; m_rcnt[k] = 8'd0;
    end
  endtask

  // Advance the model by one edge using the inputs that were present at that edge.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_t[k] = 0; m_halt[k] = 1'b0; m_wdt[k] = 0; m_cause[k] = 2'b00; m_rcnt[k] = 8'd0;
      end else if (sw_rst_req) begin
        m_t[k] = 0; m_halt[k] = 1'b0; m_wdt[k] = 0; m_cause[k] = 2'b01;
        m_rcnt[k] = sat_inc(m_rcnt[k]);
      end else if (m_halt[k]) begin
        m_halt[k] = 1'b1;
      end else if (m_t[k] < rel_time(k)) begin
        m_t[k]++;
        if (m_t[k] == rel_time(k)) m_wdt[k] = 0;
      end else if (wdt_kick) begin
        m_wdt[k] = 0;
      end else if (wdt_en && wdt_limit != 16'd0) begin
        if (m_wdt[k] + 1 == int'(wdt_limit)) begin
          m_cause[k] = 2'b10;
          if (p_ar(k)) begin
            m_t[k] = 0;
            m_rcnt[k] = sat_inc(m_rcnt[k]);
          end else begin
            m_halt[k] = 1'b1;
          end
        end else begin
          m_wdt[k]++;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic do_reset();
    rst = 1'b1; sw_rst_req = 1'b0; wdt_en = 1'b0; wdt_kick = 1'b0; wdt_limit = 16'd0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] want;
    rst = 1'b1; sw_rst_req = 1'b0; wdt_en = 1'b0; wdt_kick = 1'b0; wdt_limit = 16'd0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (obs_bus(k) !== 16'h0000) begin
        failures++;
        $display("FAIL reset_values inst%0d: got %h want 0000", k, obs_bus(k));
      end
    end
    rst = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (obs_bus(k) !== exp_bus(k)) begin
          failures++;
          $display("FAIL reset_model inst%0d cyc %0d: got %h want %h", k, n, obs_bus(k),
                   exp_bus(k));
        end
      end
      want = (n >= 11) ? 4'b1111 : (n >= 9) ? 4'b0111 : (n >= 7) ? 4'b0011 :
             (n >= 5) ? 4'b0001 : 4'b0000;
      if (n == 4 || n == 5 || n == 7 || n == 9 || n == 10 || n == 11) begin
        tests++;
        if (ch0 !== want || ready0 !== (n == 11)) begin
          failures++;
          $display("FAIL release_timing cyc %0d: got ch=%b ready=%b want ch=%b ready=%b",
                   n, ch0, ready0, want, (n == 11));
        end
      end
      if (n == 1) begin
        tests++;
        if ({ch2, ready2} !== 2'b11) begin
          failures++;
          $display("FAIL single_ch_release: got ch=%b ready=%b want 1 1", ch2, ready2);
        end
      end
    end
  endtask

  task automatic test_wdt_expiry();
    // Instance 0 sits in RUN with a frozen counter of 0.
    wdt_limit = 16'd10;
    wdt_en = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (obs_bus(k) !== exp_bus(k)) begin
          failures++;
          $display("FAIL wdt_model inst%0d cyc %0d: got %h want %h", k, n, obs_bus(k),
                   exp_bus(k));
        end
      end
      if (n == 9) begin
        tests++;
        if (ready0 !== 1'b1) begin
          failures++;
          $display("FAIL wdt_early cyc 9: got ready=%b want 1", ready0);
        end
      end
    end
    tests++;
    if ({ch0, ready0, cause0, rcnt0} !== {4'b0000, 1'b0, 2'b10, 8'd1}) begin
      failures++;
      $display("FAIL wdt_expire: got ch=%b ready=%b cause=%b rcnt=%0d want 0000 0 10 1",
               ch0, ready0, cause0, rcnt0);
    end
    for (int n = 1; n <= 11; n++) begin
      tick();
      if (n == 10 || n == 11) begin
        tests++;
        if (ready0 !== (n == 11)) begin
          failures++;
          $display("FAIL wdt_return cyc %0d: got ready=%b want %b", n, ready0, (n == 11));
        end
      end
    end
    wdt_en = 1'b0;
  endtask

  task automatic test_kick();
    bit dropped;
    do_reset();
    repeat (11) tick();
    wdt_limit = 16'd10;
    wdt_en = 1'b1;
    dropped = 1'b0;
    for (int n = 0; n < 200; n++) begin
      wdt_kick = (n % 9 == 8);
      tick();
      if (!ready0 || !ready1 || !ready2) dropped = 1'b1;
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (obs_bus(k) !== exp_bus(k)) begin
          failures++;
          $display("FAIL kick_model inst%0d cyc %0d: got %h want %h", k, n, obs_bus(k),
                   exp_bus(k));
        end
      end
    end
    tests++;
    if (dropped) begin
      failures++;
      $display("FAIL kick_periodic: got ready drop want no drop");
    end
    // Zero the counter, walk it to limit-1, then kick exactly on the expiry cycle.
    wdt_kick = 1'b1;
    tick();
    wdt_kick = 1'b0;
    repeat (9) tick();
    wdt_kick = 1'b1;
    tick();
    wdt_kick = 1'b0;
    tests++;
    if (ready0 !== 1'b1 || rcnt0 !== 8'd0) begin
      failures++;
      $display("FAIL kick_on_expiry: got ready=%b rcnt=%0d want 1 0", ready0, rcnt0);
    end
    wdt_limit = 16'd0;
    dropped = 1'b0;
    repeat (300) begin
      tick();
      if (!ready0 || !ready2 || halted1) dropped = 1'b1;
    end
    tests++;
    if (dropped) begin
      failures++;
      $display("FAIL limit_zero: got expiry want none");
    end
    wdt_en = 1'b0;
  endtask

  task automatic test_sw_rst();
    do_reset();
    repeat (7) tick();
    tests++;
    if (ch0 !== 4'b0011) begin
      failures++;
      $display("FAIL sw_pre: got ch=%b want 0011", ch0);
    end
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    tests++;
    if ({ch0, ready0, cause0, rcnt0} !== {4'b0000, 1'b0, 2'b01, 8'd1}) begin
      failures++;
      $display("FAIL sw_restart: got ch=%b ready=%b cause=%b rcnt=%0d want 0000 0 01 1",
               ch0, ready0, cause0, rcnt0);
    end
    for (int n = 1; n <= 11; n++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (obs_bus(k) !== exp_bus(k)) begin
          failures++;
          $display("FAIL sw_model inst%0d cyc %0d: got %h want %h", k, n, obs_bus(k),
                   exp_bus(k));
        end
      end
    end
    tests++;
    if (ch0 !== 4'b1111 || ready0 !== 1'b1) begin
      failures++;
      $display("FAIL sw_rerelease: got ch=%b ready=%b want 1111 1", ch0, ready0);
    end
    wdt_limit = 16'd10;
    wdt_en = 1'b1;
    repeat (9) tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    wdt_en = 1'b0;
    tests++;
    if ({ch0, cause0, rcnt0} !== {4'b0000, 2'b01, 8'd2}) begin
      failures++;
      $display("FAIL sw_vs_expiry: got ch=%b cause=%b rcnt=%0d want 0000 01 2",
               ch0, cause0, rcnt0);
    end
  endtask

  task automatic test_halt();
    bit leaked;
    do_reset();
    repeat (11) tick();
    wdt_limit = 16'd5;
    wdt_en = 1'b1;
    repeat (5) tick();
    tests++;
    if ({halted1, ready1, ch1, cause1} !== {1'b1, 1'b0, 4'b0000, 2'b10}) begin
      failures++;
      $display("FAIL halt_enter: got halted=%b ready=%b ch=%b cause=%b want 1 0 0000 10",
               halted1, ready1, ch1, cause1);
    end
    leaked = 1'b0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (!halted1 || ch1 !== 4'b0000) leaked = 1'b1;
      tests++;
      if (obs_bus(1) !== exp_bus(1)) begin
        failures++;
        $display("FAIL halt_model cyc %0d: got %h want %h", n, obs_bus(1), exp_bus(1));
      end
    end
    tests++;
    if (leaked) begin
      failures++;
      $display("FAIL halt_hold: got halt left want held");
    end
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    wdt_en = 1'b0;
    tests++;
    if (halted1 !== 1'b0 || cause1 !== 2'b01) begin
      failures++;
      $display("FAIL halt_exit: got halted=%b cause=%b want 0 01", halted1, cause1);
    end
    repeat (11) tick();
    tests++;
    if (ready1 !== 1'b1 || ch1 !== 4'b1111) begin
      failures++;
      $display("FAIL halt_resequence: got ready=%b ch=%b want 1 1111", ready1, ch1);
    end
  endtask

  task automatic test_saturate();
    bit slipped;
    do_reset();
    wdt_limit = 16'd1;
    wdt_en = 1'b1;
    slipped = 1'b0;
    for (int n = 0; n < 700; n++) begin
      tick();
      if (n > 620 && rcnt2 !== 8'd255) slipped = 1'b1;
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (obs_bus(k) !== exp_bus(k)) begin
          failures++;
          $display("FAIL sat_model inst%0d cyc %0d: got %h want %h", k, n, obs_bus(k),
                   exp_bus(k));
        end
      end
    end
    wdt_en = 1'b0;
    tests++;
    if (rcnt2 !== 8'd255 || slipped) begin
      failures++;
      $display("FAIL restart_saturate: got rcnt=%0d want 255", rcnt2);
    end
  endtask

  task automatic test_rst_mid_release();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    repeat (7) tick();
    tests++;
    if (ch0 !== 4'b0011) begin
      failures++;
      $display("FAIL rst_mid_pre: got ch=%b want 0011", ch0);
    end
    rst = 1'b1;
    #2;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (obs_bus(k) !== 16'h0000) begin
        failures++;
        $display("FAIL rst_async inst%0d: got %h want 0000", k, obs_bus(k));
      end
    end
    model_reset();
    tick();
    rst = 1'b0;
    tick();
    tests++;
    if ({ch2, ready2, ch0} !== {1'b1, 1'b1, 4'b0000}) begin
      failures++;
      $display("FAIL rst_resume: got ch2=%b ready2=%b ch0=%b want 1 1 0000", ch2, ready2,
               ch0);
    end
  endtask

  task automatic test_random();
    do_reset();
    wdt_limit = 16'd12;
    for (int n = 0; n < 2000; n++) begin
      rst        = ($urandom_range(0, 499) == 0);
      sw_rst_req = ($urandom_range(0, 99) == 0);
      wdt_kick   = ($urandom_range(0, 7) == 0);
      wdt_en     = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) wdt_limit = 16'($urandom_range(0, 20));
      tick();
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (obs_bus(k) !== exp_bus(k)) begin
          failures++;
          $display("FAIL random_model inst%0d cyc %0d: got %h want %h", k, n, obs_bus(k),
                   exp_bus(k));
        end
      end
    end
    rst = 1'b0; sw_rst_req = 1'b0; wdt_kick = 1'b0; wdt_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sw_rst_req = 1'b0; wdt_en = 1'b0; wdt_kick = 1'b0; wdt_limit = 16'd0;
    model_reset();
    test_reset();
    test_wdt_expiry();
    test_kick();
    test_sw_rst();
    test_halt();
    test_saturate();
    test_rst_mid_release();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
